// File: rtl/fof_arb_pkg.sv
// Shared types, defaults and helpers for the first-one-finder arbiter.
// Optional build macro FOF_ARB_PERF_EN enables the performance counters in fof_arbiter.
package fof_arb_pkg;

    localparam int unsigned FOF_SIZE_DEF = 31;
    localparam int unsigned FOF_NREQ_DEF = 4;
    localparam int unsigned PERF_CNT_W   = 16;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/first_one_finder.sv
// Combinational most-significant-one detector.
// Ports:
//   data_i      operand
//   max_power_o one-hot of the highest set bit of data_i, zero for a zero operand
module first_one_finder #(
    parameter int unsigned SIZE = 31
) (
    input  logic [SIZE-1:0] data_i,
    output logic [SIZE-1:0] max_power_o
);

    // Scan upward; the last set bit seen is the most significant one.
    always_comb begin
        max_power_o = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (data_i[i]) begin
                max_power_o = SIZE'(1) << i;
            end
        end
    end

endmodule

// File: rtl/fof_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr_i, with wrap.
// Ports:
//   req_valid_i  per-requester valid
//   rr_ptr_i     highest-priority requester index
//   grant_o      one-hot grant (all-zero when nothing is valid)
//   grant_idx_o  binary index of the granted requester (0 when nothing is valid)
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    logic           found_c;
    logic [IDW-1:0] cand_c;

    // Walk the ring starting at rr_ptr_i; the first valid entry wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_c     = 1'b0;
        cand_c      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = IDW'((32'(rr_ptr_i) + k) % NREQ);
            if (!found_c && req_valid_i[cand_c]) begin
                found_c         = 1'b1;
                grant_o[cand_c] = 1'b1;
                grant_idx_o     = cand_c;
            end
        end
    end

endmodule

// File: rtl/fof_arbiter.sv
// Round-robin arbiter sharing one first_one_finder between NREQ requesters,
// returning the MSB one-hot through a single registered valid/ready response slot.
// Optional macro FOF_ARB_PERF_EN adds saturating grant/stall counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester request valid
//   req_data        packed operands, requester i at [i*SIZE +: SIZE]
//   req_ready       one-hot grant (combinational)
//   rsp_valid       response slot holds a result
//   rsp_ready       consumer accepts the response
//   rsp_id          owner of the response
//   rsp_power       one-hot of the operand's highest set bit
//   rsp_zero        operand was zero
//   perf_grant_cnt  (FOF_ARB_PERF_EN) per-requester 16-bit accept counters
//   perf_stall_cnt  (FOF_ARB_PERF_EN) cycles with rsp_valid && !rsp_ready
module fof_arbiter
    import fof_arb_pkg::*;
#(
    parameter int unsigned SIZE = FOF_SIZE_DEF,
    parameter int unsigned NREQ = FOF_NREQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*SIZE-1:0]       req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [SIZE-1:0]            rsp_power,
`ifdef FOF_ARB_PERF_EN
    output logic [NREQ*PERF_CNT_W-1:0] perf_grant_cnt,
    output logic [PERF_CNT_W-1:0]      perf_stall_cnt,
`endif
    output logic                       rsp_zero
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  grant_idx_c;
    logic            slot_free_c;
    logic            accept_c;
    logic [SIZE-1:0] operand_c;
    logic [SIZE-1:0] power_c;

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [SIZE-1:0] rsp_power_q;
    logic            rsp_zero_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant_c),
        .grant_idx_o (grant_idx_c)
    );

    // Grant only when the slot can take a result; nothing is granted while in reset.
    assign slot_free_c = !rsp_valid_q || rsp_ready;
    assign req_ready   = (slot_free_c && !rst) ? grant_c : '0;
    assign accept_c    = |req_ready;
    assign rr_ptr_d    = IDW'(rr_next(32'(grant_idx_c), NREQ));

    // One-hot AND-OR mux of the granted operand.
    always_comb begin
        operand_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                operand_c = operand_c | req_data[i*SIZE +: SIZE];
            end
        end
    end

    first_one_finder #(
        .SIZE (SIZE)
    ) u_fof (
        .data_i      (operand_c),
        .max_power_o (power_c)
    );

    // Response slot and round-robin pointer; an accept reloads even while retiring.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_power_q <= '0;
            rsp_zero_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx_c;
            rsp_power_q <= power_c;
            rsp_zero_q  <= ~|power_c;
            rr_ptr_q    <= rr_ptr_d;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_power = rsp_power_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef FOF_ARB_PERF_EN
    logic [NREQ*PERF_CNT_W-1:0] perf_grant_q;
    logic [PERF_CNT_W-1:0]      perf_stall_q;

    // Saturating accept and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_ready[i] && (perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] != '1)) begin
                    perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] <=
                        perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] + PERF_CNT_W'(1);
                end
            end
            if (rsp_valid_q && !rsp_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PERF_CNT_W'(1);
            end
        end
    end

    assign perf_grant_cnt = perf_grant_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fof_arbiter.sv
// Self-checking bench for fof_arbiter: vector table, directed sequences, random vs. model.
module tb_fof_arbiter;

    localparam int unsigned SIZE = 31;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [SIZE-1:0]      rsp_power;
    logic                 rsp_zero;
`ifdef FOF_ARB_PERF_EN
    logic [NREQ*16-1:0]   perf_grant_cnt;
    logic [15:0]          perf_stall_cnt;
`endif

    fof_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_power (rsp_power),
`ifdef FOF_ARB_PERF_EN
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .rsp_zero  (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    bit              m_valid;
    int              m_id;
    logic [SIZE-1:0] m_power;
    bit              m_zero;
    int              m_gcnt[NREQ];
    int              m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Highest power of two not above x, by plain arithmetic.
    function automatic logic [SIZE-1:0] msb_of(input logic [SIZE-1:0] x);
        longint unsigned v, p;
        v = 64'(x);
        if (v == 0) return '0;
        p = 1;
        while (p <= v / 2) p = p * 2;
        return SIZE'(p);
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One clock: drive, check grant, clock, advance model, check response.
    task automatic step(input bit a_rst, input logic [NREQ-1:0] a_v,
                        input logic [NREQ*SIZE-1:0] a_d, input bit a_rr,
                        output logic [NREQ-1:0] ready_seen);
        int g;
        logic [NREQ-1:0] exp_ready;
        logic [SIZE-1:0] lane;
        @(negedge clk);
        rst = a_rst; req_valid = a_v; req_data = a_d; rsp_ready = a_rr;
        #1;
        g = (a_rst || !(!m_valid || a_rr)) ? -1 : model_pick(a_v);
        exp_ready = (g < 0) ? '0 : NREQ'(1) << g;
        ready_seen = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (a_rst) begin
            m_ptr = 0; m_valid = 0; m_id = 0; m_power = '0; m_zero = 0;
            m_stall = 0;
            for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
        end else begin
            if (m_valid && !a_rr && m_stall < 65535) m_stall++;
            if (g >= 0 && m_gcnt[g] < 65535) m_gcnt[g]++;
            if (g >= 0) begin
                lane    = a_d[g*SIZE +: SIZE];
                m_valid = 1; m_id = g; m_power = msb_of(lane); m_zero = (lane == 0);
                m_ptr   = (g + 1) % NREQ;
            end else if (m_valid && a_rr) begin
                m_valid = 0;
            end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid || a_rst) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_power", 64'(rsp_power), 64'(m_power));
            chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
        end
    endtask

    typedef struct {
        bit                   rst;
        logic [NREQ-1:0]      valid;
        logic [NREQ*SIZE-1:0] data;
        bit                   rr;
        logic [NREQ-1:0]      exp_ready;
        bit                   exp_valid;
        logic [IDW-1:0]       exp_id;
        logic [SIZE-1:0]      exp_power;
        bit                   exp_zero;
    } vec_t;

    vec_t                 vecs[9];
    logic [NREQ*SIZE-1:0] d_all, d_1234, d_zero, d;
    logic [NREQ-1:0]      rdy, v;
    bit                   r, rr;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        m_ptr = 0; m_valid = 0; m_id = 0; m_power = '0; m_zero = 0; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;

        d_all  = {31'h7FFF_FFFF, 31'h4, 31'h2, 31'h1};
        d_1234 = {31'h0, 31'h1234, 31'h0, 31'h0};
        d_zero = '0;

        //          rst valid    data    rr ready    v  id  power           zero
        vecs[0] = '{1, 4'b1111, d_all,  1, 4'b0000, 0, 0, 31'h0,          0};
        vecs[1] = '{1, 4'b1111, d_all,  1, 4'b0000, 0, 0, 31'h0,          0};
        vecs[2] = '{0, 4'b1111, d_all,  1, 4'b0001, 1, 0, 31'h1,          0};
        vecs[3] = '{0, 4'b0100, d_1234, 1, 4'b0100, 1, 2, 31'h1000,       0};
        vecs[4] = '{0, 4'b0010, d_zero, 1, 4'b0010, 1, 1, 31'h0,          1};
        vecs[5] = '{0, 4'b0000, d_zero, 1, 4'b0000, 0, 0, 31'h0,          0};
        vecs[6] = '{0, 4'b1001, d_all,  1, 4'b1000, 1, 3, 31'h4000_0000,  0};
        vecs[7] = '{0, 4'b1001, d_all,  0, 4'b0000, 1, 3, 31'h4000_0000,  0};
        vecs[8] = '{0, 4'b1001, d_all,  1, 4'b0001, 1, 0, 31'h1,          0};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].rr, rdy);
            chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(vecs[i].exp_ready));
            chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid || vecs[i].rst) begin
                chk($sformatf("tbl%0d_id", i), 64'(rsp_id), 64'(vecs[i].exp_id));
                chk($sformatf("tbl%0d_power", i), 64'(rsp_power), 64'(vecs[i].exp_power));
                chk($sformatf("tbl%0d_zero", i), 64'(rsp_zero), 64'(vecs[i].exp_zero));
            end
        end

        // Fairness: all valid, consumer always ready -> ids 0,1,2,3,0,1,2,3 with no bubbles.
        step(1, 4'b1111, d_all, 1, rdy);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b1111, d_all, 1, rdy);
            chk("fair_valid", 64'(rsp_valid), 64'(1));
            chk("fair_id", 64'(rsp_id), 64'(i % 4));
        end

        // Backpressure: hold the slot for 5 cycles, then retire and reload together.
        step(1, 4'b0000, d_all, 1, rdy);
        step(0, 4'b1001, d_all, 1, rdy);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1001, d_all, 0, rdy);
            chk("bp_ready", 64'(rdy), 64'(0));
            chk("bp_id", 64'(rsp_id), 64'(0));
            chk("bp_power", 64'(rsp_power), 64'(1));
            chk("bp_valid", 64'(rsp_valid), 64'(1));
        end
`ifdef FOF_ARB_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(5));
`endif
        step(0, 4'b1001, d_all, 1, rdy);
        chk("bp_release_ready", 64'(rdy), 64'(4'b1000));
        chk("bp_release_id", 64'(rsp_id), 64'(3));
        chk("bp_release_valid", 64'(rsp_valid), 64'(1));

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = NREQ'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                d[i*SIZE +: SIZE] = ($urandom_range(0, 7) == 0) ? '0
                                  : SIZE'($urandom >> $urandom_range(0, 31));
            end
            step(r, v, d, rr, rdy);
        end
`ifdef FOF_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("perf_grant%0d", i), 64'(perf_grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
        end
        chk("perf_stall_rand", 64'(perf_stall_cnt), 64'(m_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
